// File: rtl/taiga_types.sv
// Shared AXI encodings (response codes, burst types) used across the taiga memory-side blocks.
package taiga_types;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_mem_bram.sv
// Simple dual-port word RAM: one registered read port that holds its output when idle,
// one byte-enabled write port. Read-first on a same-cycle read/write collision.
module axi_mem_bram #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata,
    input  logic                           we,
    input  logic [3:0]                     wbe,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip RAM; independent read and write FSMs over a dual-port RAM.
// Optional bounds checking (DECERR, dropped writes) is enabled by defining AXI_MEM_BOUNDS_CHECK_EN.
module axi_mem_responder
    import taiga_types::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic [5:0]  axi_arid,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic [5:0]  axi_rid,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    output logic [1:0]  rd_state_dbg,
    output logic [1:0]  wr_state_dbg
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [30:0] DEPTH_IDX = 31'(DEPTH_WORDS);
`ifdef AXI_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Unwrapped word index; an address below ADDR_BASE borrows into bit 30 and so lands out of range.
    function automatic logic [30:0] word_index(input logic [31:0] addr);
        return 31'(({1'b0, addr} - {1'b0, ADDR_BASE}) >> 2);
    endfunction

    function automatic logic beat_err(input logic [30:0] idx);
        return BOUNDS_EN && (idx >= DEPTH_IDX);
    endfunction

    // Every channel transfers on a rising edge where valid and ready are both high; a valid
    // source holds its payload unchanged until that edge, and ready never waits on valid.

    logic           ram_re;
    logic [AW-1:0]  ram_raddr;
    logic [31:0]    ram_rdata;
    logic           ram_we;

    r_state_t       r_state;
    logic           arready_q, rvalid_q, rlast_q, r_err_q;
    logic [1:0]     rresp_q;
    logic [5:0]     rid_q;
    logic [30:0]    r_idx;
    logic [30:0]    r_idx_next;
    logic [7:0]     r_len, r_cnt;

    w_state_t       w_state;
    logic           awready_q, wready_q, bvalid_q, w_err_q;
    logic [1:0]     bresp_q;
    logic [30:0]    w_idx;
    logic [7:0]     w_len, w_cnt;
    logic           w_beat, w_beat_err;

    assign r_idx_next = r_idx + 31'd1;

    // The next beat's fetch is issued on the accepting handshake so the data phase has no bubble.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = r_idx[AW-1:0];
        if (r_state == R_FETCH) begin
            ram_re = 1'b1;
        end else if (r_state == R_DATA && axi_rready && !rlast_q) begin
            ram_re    = 1'b1;
            ram_raddr = r_idx_next[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            r_err_q   <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
            rid_q     <= 6'd0;
            r_idx     <= 31'd0;
            r_len     <= 8'd0;
            r_cnt     <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (axi_arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        r_idx     <= word_index(axi_araddr);
                        r_len     <= axi_arlen;
                        rid_q     <= axi_arid;
                        r_cnt     <= 8'd0;
                        r_state   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= (r_len == 8'd0);
                    r_err_q  <= beat_err(r_idx);
                    rresp_q  <= beat_err(r_idx) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (axi_rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            r_err_q   <= 1'b0;
                            rresp_q   <= AXI_RESP_OKAY;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_idx   <= r_idx_next;
                            r_cnt   <= r_cnt + 8'd1;
                            rlast_q <= (r_cnt + 8'd1 == r_len);
                            r_err_q <= beat_err(r_idx_next);
                            rresp_q <= beat_err(r_idx_next) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign axi_arready  = arready_q;
    assign axi_rvalid   = rvalid_q;
    assign axi_rlast    = rlast_q;
    assign axi_rresp    = rresp_q;
    assign axi_rid      = rid_q;
    assign axi_rdata    = (rvalid_q && !r_err_q) ? ram_rdata : 32'h0;
    assign rd_state_dbg = r_state;

    assign w_beat     = (w_state == W_DATA) && axi_wvalid && wready_q;
    assign w_beat_err = beat_err(w_idx);
    assign ram_we     = w_beat && !w_beat_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            w_err_q   <= 1'b0;
            w_idx     <= 31'd0;
            w_len     <= 8'd0;
            w_cnt     <= 8'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (axi_awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_idx     <= word_index(axi_awaddr);
                        w_len     <= axi_awlen;
                        w_cnt     <= 8'd0;
                        w_err_q   <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_idx   <= w_idx + 31'd1;
                        w_cnt   <= w_cnt + 8'd1;
                        w_err_q <= w_err_q | w_beat_err;
                        if (axi_wlast) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            // A decode error anywhere in the burst outranks a length mismatch.
                            if (w_err_q || w_beat_err) bresp_q <= AXI_RESP_DECERR;
                            else if (w_cnt != w_len)   bresp_q <= AXI_RESP_SLVERR;
                            else                       bresp_q <= AXI_RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= AXI_RESP_OKAY;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign axi_awready  = awready_q;
    assign axi_wready   = wready_q;
    assign axi_bvalid   = bvalid_q;
    assign axi_bresp    = bresp_q;
    assign wr_state_dbg = w_state;

    axi_mem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .wbe   (axi_wstrb),
        .waddr (w_idx[AW-1:0]),
        .wdata (axi_wdata)
    );

    // Size and burst type are fixed by construction (4-byte INCR), so these inputs carry no information.
    logic unused_ok;
    assign unused_ok = ^{axi_arsize, axi_arburst, axi_awsize, axi_awburst};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, backpressure, strobes, SLVERR, read-first, reset.
`timescale 1ns/1ps
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic [5:0]  axi_arid;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic [5:0]  axi_rid;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic [1:0]  rd_state_dbg, wr_state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wq[$];

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arid(axi_arid),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rid(axi_rid),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Writes wq[0..nbeats-1]; wlast on the final beat; checks B timing and response.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input int nbeats, input logic [3:0] strb, input logic [1:0] exp_resp);
        chk({tag, "_awready"}, axi_awready, 1'b1);
        axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = len;
        tick();
        axi_awvalid = 1'b0;
        chk({tag, "_wready"}, axi_wready, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            chk({tag, "_bvalid_early"}, axi_bvalid, 1'b0);
            axi_wvalid = 1'b1; axi_wdata = wq[i]; axi_wstrb = strb;
            axi_wlast = (i == nbeats - 1);
            tick();
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        chk({tag, "_bvalid"}, axi_bvalid, 1'b1);
        chk({tag, "_bresp"}, axi_bresp, exp_resp);
        chk({tag, "_wready_off"}, axi_wready, 1'b0);
        axi_bready = 1'b1;
        tick();
        axi_bready = 1'b0;
        chk({tag, "_bvalid_drop"}, axi_bvalid, 1'b0);
        chk({tag, "_awready_again"}, axi_awready, 1'b1);
    endtask

    // Reads len+1 beats and checks them against exp_q; toggle=1 alternates rready 0/1.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [5:0] id, input bit toggle);
        int beats;
        int cyc;
        chk({tag, "_arready"}, axi_arready, 1'b1);
        axi_arvalid = 1'b1; axi_araddr = addr; axi_arlen = len; axi_arid = id;
        tick();
        axi_arvalid = 1'b0;
        chk({tag, "_rvalid_fetch"}, axi_rvalid, 1'b0);
        tick();
        beats = 0;
        cyc = 0;
        while (beats <= int'(len) && cyc < 600) begin
            axi_rready = toggle ? cyc[0] : 1'b1;
            chk({tag, "_rvalid"}, axi_rvalid, 1'b1);
            chk({tag, "_rdata"}, axi_rdata, exp_q[0]);
            chk({tag, "_rid"}, axi_rid, id);
            chk({tag, "_rresp"}, axi_rresp, 2'b00);
            chk({tag, "_rlast"}, axi_rlast, beats == int'(len));
            if (axi_rready) begin
                void'(exp_q.pop_front());
                beats++;
            end
            tick();
            cyc++;
        end
        axi_rready = 1'b0;
        chk({tag, "_beats"}, beats, int'(len) + 1);
        chk({tag, "_rvalid_end"}, axi_rvalid, 1'b0);
        chk({tag, "_arready_end"}, axi_arready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        axi_arvalid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 3'd2; axi_arburst = 2'b01; axi_arid = 0;
        axi_rready = 0;
        axi_awvalid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 3'd2; axi_awburst = 2'b01;
        axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_bready = 0;
        repeat (3) tick();

        // Reset values
        chk("rst_arready", axi_arready, 1'b0);
        chk("rst_awready", axi_awready, 1'b0);
        chk("rst_rvalid", axi_rvalid, 1'b0);
        chk("rst_rlast", axi_rlast, 1'b0);
        chk("rst_rresp", axi_rresp, 2'b00);
        chk("rst_rid", axi_rid, 6'd0);
        chk("rst_rdata", axi_rdata, 32'h0);
        chk("rst_wready", axi_wready, 1'b0);
        chk("rst_bvalid", axi_bvalid, 1'b0);
        chk("rst_bresp", axi_bresp, 2'b00);
        chk("rst_rd_state", rd_state_dbg, 2'd0);
        chk("rst_wr_state", wr_state_dbg, 2'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_arready", axi_arready, 1'b1);
        chk("post_rst_awready", axi_awready, 1'b1);

        // 8-beat write then read back, continuous rready
        wq = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        do_write("wr8", 32'h100, 8'd7, 8, 4'hF, 2'b00);
        exp_q = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        do_read("rd8", 32'h100, 8'd7, 6'h05, 1'b0);

        // Same burst with rready toggling
        exp_q = {32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        do_read("rd8_bp", 32'h100, 8'd7, 6'h2A, 1'b1);

        // Byte strobes
        wq = {32'hFFFF_FFFF};
        do_write("wr_ff", 32'h40, 8'd0, 1, 4'hF, 2'b00);
        wq = {32'hAABB_CCDD};
        do_write("wr_strb", 32'h40, 8'd0, 1, 4'b0101, 2'b00);
        exp_q = {32'hFFBB_FFDD};
        do_read("rd_strb", 32'h40, 8'd0, 6'h01, 1'b0);

        // Early wlast: awlen=3 but only 2 beats
        wq = {32'h1000_0001, 32'h1000_0002};
        do_write("wr_short", 32'h300, 8'd3, 2, 4'hF, 2'b10);
        exp_q = {32'h1000_0001, 32'h1000_0002};
        do_read("rd_short", 32'h300, 8'd1, 6'h3F, 1'b0);

        // Concurrent read and write of the same 4 words, address phases in the same cycle
        axi_arvalid = 1'b1; axi_araddr = 32'h100; axi_arlen = 8'd3; axi_arid = 6'h0C;
        axi_awvalid = 1'b1; axi_awaddr = 32'h100; axi_awlen = 8'd3;
        tick();
        axi_arvalid = 1'b0; axi_awvalid = 1'b0;
        wq = {32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
        exp_q = {32'h11, 32'h22, 32'h33, 32'h44};
        axi_rready = 1'b1; axi_bready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                axi_wvalid = 1'b1; axi_wdata = wq[c]; axi_wstrb = 4'hF; axi_wlast = (c == 3);
            end else begin
                axi_wvalid = 1'b0; axi_wlast = 1'b0;
            end
            if (c >= 1 && c <= 4) begin
                chk("cc_rvalid", axi_rvalid, 1'b1);
                chk("cc_rdata_old", axi_rdata, exp_q[0]);
                chk("cc_rlast", axi_rlast, c == 4);
                void'(exp_q.pop_front());
            end
            if (c == 4) begin
                chk("cc_bvalid", axi_bvalid, 1'b1);
                chk("cc_bresp", axi_bresp, 2'b00);
            end
            tick();
        end
        axi_rready = 1'b0; axi_bready = 1'b0;
        chk("cc_arready_end", axi_arready, 1'b1);
        chk("cc_awready_end", axi_awready, 1'b1);
        exp_q = {32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
        do_read("cc_rd_new", 32'h100, 8'd3, 6'h0D, 1'b0);

        // Reset during beat 3 of a 16-beat read
        axi_arvalid = 1'b1; axi_araddr = 32'h100; axi_arlen = 8'd15; axi_arid = 6'h07;
        tick();
        axi_arvalid = 1'b0;
        tick();
        axi_rready = 1'b1;
        repeat (3) tick();
        chk("mid_rvalid_before", axi_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid_async", axi_rvalid, 1'b0);
        chk("mid_arready_async", axi_arready, 1'b0);
        chk("mid_rd_state", rd_state_dbg, 2'd0);
        axi_rready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mid_arready_after", axi_arready, 1'b1);
        exp_q = {32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004,
                 32'h55, 32'h66, 32'h77, 32'h88};
        do_read("mid_rd_again", 32'h100, 8'd7, 6'h09, 1'b0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
